// File: rtl/queue_drain_pkg.sv
// Shared FSM encoding and default widths for the queue drain controller.
package queue_drain_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/queue_drain_buf.sv
// drain_buf: small output FIFO with wrap-around pointers and a registered head.
module drain_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // pointers carry an extra wrap bit so full and empty are distinguishable
  assign occ   = wr_ptr - rd_ptr;
  assign full  = (occ == (PTR_W+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[PTR_W-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/queue_drain.sv
// Drains a 1-cycle-latency queue into a ready/valid stream under a credit limit.
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | issuing reads while credit allows, until the queue reports empty
//   FINISH | no more reads; waiting for the buffer and in-flight read to drain
module queue_drain
  import queue_drain_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              q_read,
  input  logic              q_valid,
  input  logic [DATA_W-1:0] q_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic             outstanding;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   inflight;
  logic             buf_full;
  logic             buf_empty;
  logic             credit_ok;
  logic             resp_empty;
  logic             wr_en;
  logic             xfer;

  assign resp_empty = outstanding && !q_valid;
  assign wr_en      = outstanding && q_valid;
  assign m_valid    = !buf_empty;
  assign xfer       = m_valid && m_ready;
  assign busy       = (state != IDLE);

  // occupancy counts only registered entries, so a read is granted only when
  // the slot for its response is guaranteed even if nothing drains meanwhile
  assign inflight  = {1'b0, occ} + {{OCC_W{1'b0}}, outstanding};
  assign credit_ok = !buf_full && (inflight < (OCC_W+1)'(BUF_DEPTH));

  drain_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (q_data),
    .rd_en   (xfer),
    .head    (m_data),
    .full    (buf_full),
    .empty   (buf_empty),
    .occ     (occ)
  );

  always_comb begin
    state_nxt = state;
    q_read    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (resp_empty) state_nxt = FINISH;
        else if (credit_ok) q_read = 1'b1;
      end
      FINISH: begin
        if (buf_empty && !outstanding) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      outstanding <= 1'b0;
      count       <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= q_read;
      if (state == IDLE && start) count <= '0;
      else if (xfer && count != '1) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_queue_drain.sv
// Randomized scoreboard bench for queue_drain: a queue model feeds the DUT and
// a monitor checks the delivered stream, credits and session results.
module tb_queue_drain;

  localparam int DATA_W    = 8;
  localparam int CNT_W     = 11;
  localparam int BUF_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              q_read;
  logic              q_valid = 1'b0;
  logic [DATA_W-1:0] q_data = '0;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  queue_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .q_read  (q_read),
    .q_valid (q_valid),
    .q_data  (q_data),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  logic [DATA_W-1:0] src_q[$];   // words still sitting in the external queue
  logic [DATA_W-1:0] exp_q[$];   // words the stream must still deliver, in order
  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;              // 0 always, 1 toggle, 2 hold low, 3 random
  int exp_count = 0;
  int reads_total = 0;
  int xfers_total = 0;
  int tb_occ = 0;
  bit out_prev = 1'b0;
  bit done_prev = 1'b0;
  bit mvalid_seen = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // queue model: answers each read one cycle later; junk when nothing was asked
  initial begin : driver
    bit rd_now;
    forever begin
      @(negedge clk);
      rd_now = q_read && rst_n;
      @(posedge clk);
      #1;
      if (rd_now) begin
        if (src_q.size() > 0) begin
          q_valid = 1'b1;
          q_data  = src_q.pop_front();
        end else begin
          q_valid = 1'b0;
          q_data  = 8'($urandom);
        end
      end else begin
        q_valid = 1'b1;
        q_data  = 8'($urandom);
      end
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'b0;
        default: m_ready = 1'($urandom);
      endcase
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tb_occ = 0;
        out_prev = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (q_read) begin
          reads_total++;
          chk("credit", (tb_occ + int'(out_prev)) < BUF_DEPTH, 1);
        end
        chk("m_valid", m_valid, tb_occ > 0);
        if (m_valid) mvalid_seen = 1'b1;
        if (m_valid && m_ready) begin
          xfers_total++;
          if (exp_q.size() == 0) chk("xfer_unexpected", m_data, -1);
          else chk("m_data", m_data, exp_q.pop_front());
        end
        if (done) begin
          chk("done_width", done_prev, 0);
          chk("done_count", count, exp_count);
          chk("done_drained", exp_q.size(), 0);
        end
        tb_occ = tb_occ + ((out_prev && q_valid) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        out_prev = q_read;
        done_prev = done;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_word(input logic [DATA_W-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    chk({name, "_done_seen"}, seen, 1);
    @(negedge clk);
    chk({name, "_idle_after"}, busy, 0);
  endtask

  task automatic run_session(input int budget, input string name);
    exp_count = exp_q.size();
    pulse_start();
    wait_done(budget, name);
  endtask

  initial begin : main
    int r0;
    int x0;
    logic [DATA_W-1:0] first;

    repeat (2) @(negedge clk);
    chk("rst_q_read", q_read, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    @(posedge clk); #3; rst_n = 1'b1;

    // three ordered words, free-flowing sink
    rdy_mode = 0;
    push_word(8'h01); push_word(8'h02); push_word(8'h03);
    run_session(50, "seq3");

    // empty queue: one read, quick done, no output
    mvalid_seen = 1'b0;
    r0 = reads_total;
    exp_count = 0;
    pulse_start();
    wait_done(3, "empty");
    chk("empty_reads", reads_total - r0, 1);
    chk("empty_mvalid_seen", mvalid_seen, 0);

    // long run with alternating back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 1030; i++) push_word(8'h03);
    x0 = xfers_total;
    run_session(5000, "bulk");
    chk("bulk_xfers", xfers_total - x0, 1030);

    // long stall: reads stop at the credit limit, head stays put
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) push_word(8'($urandom));
    first = exp_q[0];
    exp_count = 5;
    r0 = reads_total;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i > 4) chk("stall_head", m_data, first);
    end
    chk("stall_reads", reads_total - r0, 2);
    chk("stall_m_valid", m_valid, 1);
    rdy_mode = 0;
    wait_done(200, "stall");

    // reset mid-session with two words buffered, then restart
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) push_word(8'($urandom));
    exp_count = 6;
    pulse_start();
    repeat (6) @(negedge clk);
    chk("mid_m_valid", m_valid, 1);
    @(posedge clk); #2; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_q_read", q_read, 0);
    @(posedge clk); #3; rst_n = 1'b1;
    chk("mid_rst_remaining", src_q.size(), 4);
    exp_q.delete();
    foreach (src_q[i]) exp_q.push_back(src_q[i]);
    rdy_mode = 3;
    run_session(300, "restart");

    // start pulses while busy must not disturb the session
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) push_word(8'($urandom));
    exp_count = 12;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      repeat (3) @(posedge clk);
      #1;
      chk("busy_when_restart", busy, 1);
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_done(300, "busy_start");

    // random sessions with random back-pressure
    for (int s = 0; s < 5; s++) begin
      rdy_mode = 3;
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) push_word(8'($urandom));
      run_session(400, "rand");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
